// File: rtl/dive_pkg.sv
// Shared definitions for the dive game controller: state encoding and
// default timing parameters.
package dive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    OVER    = 2'd3
  } dive_state_t;

  localparam int unsigned FRAMES_PER_SEC_DEF = 60;
  localparam int unsigned LOW_THRESH_DEF     = 5;
  localparam int unsigned BLINK_HALF_DEF     = 15;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers the previous level and flags a 0->1 step.
// RESET_VAL selects what "previous" looks like after reset, so a level held
// high through reset can be made to produce no edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic fps,
  input  logic resetn,
  input  logic level,
  output logic rise
);

  logic prev;

  // Track the level seen on the previous frame.
  always_ff @(posedge fps or negedge resetn) begin
    if (!resetn) begin
      prev <= RESET_VAL;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/dive_controller.sv
// Dive game controller: game state machine, game-second timebase, survival
// counter, oxygen refill / reload pulses and blinking low-oxygen warning.
module dive_controller
  import dive_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int unsigned LOW_THRESH     = LOW_THRESH_DEF,
  parameter int unsigned BLINK_HALF     = BLINK_HALF_DEF
) (
  input  logic       fps,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] collisions,
  input  logic [3:0] upperDigit,
  input  logic [3:0] lowerDigit,
  input  logic       gameOver,
  output logic [1:0] state,
  output logic       secTick,
  output logic       refill,
  output logic       clearOxy,
  output logic       lowWarn,
  output logic [7:0] survived
);

  localparam int unsigned FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int unsigned BW = $clog2(2 * BLINK_HALF);

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);
  localparam logic [3:0]    THRESH     = 4'(LOW_THRESH);

  dive_state_t   state_q;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;

  logic start_rise;
  logic pause_rise;
  logic bubble_rise;
  logic in_bubble;
  logic warn_cond;

  assign in_bubble = |collisions;
  assign warn_cond = (state_q == PLAYING) && (upperDigit == 4'd0) &&
                     (lowerDigit <= THRESH);
  assign state     = state_q;

  // Buttons reset their history to 1 so a press held through reset is
  // not seen as an edge; the bubble history resets to 0.
  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .fps(fps), .resetn(resetn), .level(start), .rise(start_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_pause_rise (
    .fps(fps), .resetn(resetn), .level(pause), .rise(pause_rise)
  );

  rise_detect #(.RESET_VAL(1'b0)) u_bubble_rise (
    .fps(fps), .resetn(resetn), .level(in_bubble), .rise(bubble_rise)
  );

  // Game state machine with all outputs registered alongside it.
  always_ff @(posedge fps or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      frame_cnt <= '0;
      blink_cnt <= '0;
      secTick   <= 1'b0;
      refill    <= 1'b0;
      clearOxy  <= 1'b0;
      lowWarn   <= 1'b0;
      survived  <= 8'd0;
    end else begin
      // Single-cycle pulses default low and are raised only where needed.
      secTick  <= 1'b0;
      refill   <= 1'b0;
      clearOxy <= 1'b0;

      // A new bubble contact refills only during play; edges elsewhere are
      // dropped rather than queued.
      if (state_q == PLAYING && bubble_rise) begin
        refill <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          frame_cnt <= '0;
          if (start_rise) begin
            state_q  <= PLAYING;
            clearOxy <= 1'b1;
            survived <= 8'd0;
          end
        end
        PLAYING: begin
          if (gameOver) begin
            state_q   <= OVER;
            frame_cnt <= '0;
          end else if (pause_rise) begin
            // Frame position is frozen so play resumes mid-second.
            state_q <= PAUSED;
          end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            secTick   <= 1'b1;
            if (survived != 8'hFF) begin
              survived <= survived + 8'd1;
            end
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end
        PAUSED: begin
          if (pause_rise) begin
            state_q <= PLAYING;
          end
        end
        OVER: begin
          frame_cnt <= '0;
          if (start_rise) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Warning blinks high for the first half of each period; a pause
      // freezes the blink phase and the lamp.
      if (warn_cond) begin
        lowWarn   <= (blink_cnt < BLINK_MID);
        blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
      end else if (state_q != PAUSED) begin
        lowWarn   <= 1'b0;
        blink_cnt <= '0;
      end
    end
  end

endmodule
